light_mode_controller: RTL and testbench

LIGHT_MODE_CONTROLLER -- requirements
Module: light_mode_controller

---
 rtl/light_pkg.sv | 27 ++
 rtl/light_tick_gen.sv | 24 ++
 rtl/light_mode_controller.sv | 131 +++++++++++++
 tb/tb_light_mode_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared types, defaults and the ramp step helper for the light mode controller.
package light_pkg;

   typedef logic [7:0] level_t;

   typedef enum logic [2:0] {
      LS_IDLE      = 3'd0,
      LS_RAMP_UP   = 3'd1,
      LS_ON        = 3'd2,
      LS_RAMP_DOWN = 3'd3
   } light_state_e;

   localparam int DEF_TICK_DIV   = 1000;
   localparam int DEF_STEP       = 8;
   localparam int DEF_HOLD_TICKS = 600;

   // Move cur toward tgt by at most step; lands exactly on tgt, never overshoots or wraps.
   function automatic level_t step_toward(input level_t cur, input level_t tgt, input level_t step);
      if (cur < tgt)
         return ((tgt - cur) > step) ? (cur + step) : tgt;
      else if (cur > tgt)
         return ((cur - tgt) > step) ? (cur - step) : tgt;
      else
         return cur;
   endfunction

endpackage

// File: rtl/light_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, down-counter with terminal compare.
module light_tick_gen #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= (cnt == '0) ? CW'(TICK_DIV - 1) : cnt - CW'(1);
         tick <= (cnt == CW'(1));
      end
   end

endmodule

// File: rtl/light_mode_controller.sv
// Manual/auto light sequencer with ramped dimming and auto-off hold timer.
// Optional auto-mode intensity ceiling: define LIGHT_NIGHT_CAP_EN.
//
// state     | meaning
// IDLE      | light off, waiting for manual or auto request
// RAMP_UP   | stepping dim_level toward target once per tick
// ON        | tracking target, hold timer counting down when no trigger
// RAMP_DOWN | stepping dim_level to 0, any request recaptures
module light_mode_controller
   import light_pkg::*;
#(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int STEP       = DEF_STEP,
   parameter int HOLD_TICKS = DEF_HOLD_TICKS,
   parameter int NIGHT_CAP  = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       app_switch,
   input  logic       movement,
   input  logic       dark,
   input  logic [7:0] room_intensity,
   output logic [7:0] dim_level,
   output logic       light_en,
   output logic [2:0] state,
   output logic       src_manual
);

   localparam logic [2:0] IDLE      = LS_IDLE;
   localparam logic [2:0] RAMP_UP   = LS_RAMP_UP;
   localparam logic [2:0] ON        = LS_ON;
   localparam logic [2:0] RAMP_DOWN = LS_RAMP_DOWN;

   localparam int     HW       = $clog2(HOLD_TICKS + 1);
   localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_TICKS);
   localparam level_t STEP_L   = level_t'(STEP);
   localparam level_t CAP_L    = level_t'(NIGHT_CAP);
`ifdef LIGHT_NIGHT_CAP_EN
   localparam bit     CAP_EN   = 1'b1;
`else
   localparam bit     CAP_EN   = 1'b0;
`endif

   logic          tick;
   logic          manual_req;
   logic          auto_trig;
   level_t        tgt_auto;
   level_t        target;
   level_t        dim_nxt;
   logic [2:0]    state_nxt;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_nxt;

   light_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign manual_req = app_switch;
   assign auto_trig  = movement & dark;
   assign tgt_auto   = (CAP_EN && (room_intensity > CAP_L)) ? CAP_L : room_intensity;

   always_comb begin
      state_nxt = state;
      dim_nxt   = dim_level;
      hold_nxt  = hold_cnt;
      target    = manual_req ? room_intensity : tgt_auto;
      case (state)
         IDLE: begin
            dim_nxt = '0;
            if (manual_req || auto_trig) begin
               state_nxt = RAMP_UP;
               hold_nxt  = HOLD_LD;
            end
         end
         RAMP_UP: begin
            if (auto_trig)
               hold_nxt = HOLD_LD;
            if (tick)
               dim_nxt = step_toward(dim_level, target, STEP_L);
            if (dim_nxt == target)
               state_nxt = ON;
         end
         ON: begin
            if (tick)
               dim_nxt = step_toward(dim_level, target, STEP_L);
            // A trigger landing on a tick reloads rather than decrements.
            if (auto_trig)
               hold_nxt = HOLD_LD;
            else if (tick && (hold_cnt != '0))
               hold_nxt = hold_cnt - HW'(1);
            if (!manual_req && (hold_cnt == '0))
               state_nxt = RAMP_DOWN;
         end
         RAMP_DOWN: begin
            target = '0;
            if (manual_req || auto_trig) begin
               state_nxt = RAMP_UP;
               hold_nxt  = HOLD_LD;
            end else begin
               if (tick)
                  dim_nxt = step_toward(dim_level, target, STEP_L);
               if (dim_level == '0)
                  state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            dim_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         dim_level  <= '0;
         light_en   <= 1'b0;
         src_manual <= 1'b0;
         hold_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         dim_level  <= dim_nxt;
         light_en   <= (dim_nxt != '0);
         src_manual <= manual_req;
         hold_cnt   <= hold_nxt;
      end
   end

endmodule

// File: tb/tb_light_mode_controller.sv
// Directed scoreboard bench for light_mode_controller (TICK_DIV=4, STEP=16, HOLD_TICKS=3).
module tb_light_mode_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       app_switch;
   logic       movement;
   logic       dark;
   logic [7:0] room_intensity;
   logic [7:0] dim_level;
   logic       light_en;
   logic [2:0] state;
   logic       src_manual;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int gap;
   int exp_auto;

   light_mode_controller #(
      .TICK_DIV   (4),
      .STEP       (16),
      .HOLD_TICKS (3),
      .NIGHT_CAP  (64)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .app_switch     (app_switch),
      .movement       (movement),
      .dark           (dark),
      .room_intensity (room_intensity),
      .dim_level      (dim_level),
      .light_en       (light_en),
      .state          (state),
      .src_manual     (src_manual)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pop each queued level in order as dim_level changes; gap = cycles waited for the last one.
   task automatic pop_changes(input string tag, input int budget);
      int e;
      int n;
      logic [7:0] last;
      while (exp_q.size() > 0) begin
         e    = exp_q.pop_front();
         last = dim_level;
         n    = 0;
         while ((dim_level === last) && (n < budget)) begin
            @(negedge clk);
            n++;
         end
         gap = n;
         check(tag, int'(dim_level), e);
      end
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
      int n = 0;
      while ((state !== s) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      check(tag, int'(state), int'(s));
   endtask

   task automatic auto_pulse(input logic [7:0] lvl);
      room_intensity = lvl;
      movement = 1'b1;
      dark     = 1'b1;
      @(negedge clk);
      movement = 1'b0;
      dark     = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      app_switch = 1'b0;
      movement = 1'b0;
      dark = 1'b0;
      room_intensity = 8'd0;
      repeat (2) @(negedge clk);
      check("rst_dim", int'(dim_level), 0);
      check("rst_state", int'(state), 0);
      check("rst_en", int'(light_en), 0);
      check("rst_src", int'(src_manual), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // manual ramp to 64
      app_switch = 1'b1;
      room_intensity = 8'd64;
      exp_q.push_back(16);
      pop_changes("man_first", 8);
      check("man_latency_ok", int'(gap <= 5), 1);
      exp_q.push_back(32); exp_q.push_back(48); exp_q.push_back(64);
      pop_changes("man_up", 8);
      check("man_step_gap", gap, 4);
      @(negedge clk);
      check("man_state_on", int'(state), 2);
      check("man_src", int'(src_manual), 1);
      check("man_en", int'(light_en), 1);
      app_switch = 1'b0;
      exp_q.push_back(48); exp_q.push_back(32); exp_q.push_back(16); exp_q.push_back(0);
      pop_changes("man_down", 30);
      wait_state("man_idle", 3'd0, 10);
      check("man_off_en", int'(light_en), 0);

      // movement without dark does nothing
      movement = 1'b1;
      room_intensity = 8'd100;
      repeat (20) @(negedge clk);
      check("nodark_dim", int'(dim_level), 0);
      check("nodark_state", int'(state), 0);
      movement = 1'b0;

      // auto single-cycle trigger, ramp to 40, hold 3 ticks, ramp down
      auto_pulse(8'd40);
      exp_q.push_back(16); exp_q.push_back(32); exp_q.push_back(40);
      pop_changes("auto_up", 8);
      @(negedge clk);
      check("auto_state_on", int'(state), 2);
      check("auto_src", int'(src_manual), 0);
      exp_q.push_back(24);
      pop_changes("auto_hold_end", 30);
      check("auto_hold_gap", gap + 1, 16);
      exp_q.push_back(8); exp_q.push_back(0);
      pop_changes("auto_down", 8);
      wait_state("auto_idle", 3'd0, 10);

      // recapture from RAMP_DOWN at 24
      auto_pulse(8'd40);
      exp_q.push_back(16); exp_q.push_back(32); exp_q.push_back(40); exp_q.push_back(24);
      pop_changes("recap_pre", 30);
      app_switch = 1'b1;
      room_intensity = 8'd64;
      repeat (2) @(negedge clk);
      check("recap_state", int'(state), 1);
      check("recap_hold_lvl", int'(dim_level), 24);
      exp_q.push_back(40); exp_q.push_back(56); exp_q.push_back(64);
      pop_changes("recap_up", 8);
      wait_state("recap_on", 3'd2, 4);
      app_switch = 1'b0;
      exp_q.push_back(48); exp_q.push_back(32);
      pop_changes("recap_down", 30);

      // async reset at 32
      #2 rst = 1'b1;
      #1;
      check("arst_dim", int'(dim_level), 0);
      check("arst_state", int'(state), 0);
      check("arst_en", int'(light_en), 0);
      app_switch = 1'b1;
      room_intensity = 8'd64;
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(16);
      pop_changes("arst_restart", 8);
      wait_state("arst_on", 3'd2, 20);
      check("arst_on_dim", int'(dim_level), 64);
      app_switch = 1'b0;
      wait_state("arst_idle", 3'd0, 60);

      // zero intensity while requested
      app_switch = 1'b1;
      room_intensity = 8'd0;
      wait_state("zero_on", 3'd2, 10);
      check("zero_dim", int'(dim_level), 0);
      check("zero_en", int'(light_en), 0);
      app_switch = 1'b0;
      wait_state("zero_idle", 3'd0, 40);

      // night cap: auto limited when enabled, manual never
`ifdef LIGHT_NIGHT_CAP_EN
      exp_auto = 64;
`else
      exp_auto = 200;
`endif
      auto_pulse(8'd200);
      wait_state("cap_auto_on", 3'd2, 100);
      check("cap_auto_dim", int'(dim_level), exp_auto);
      wait_state("cap_auto_idle", 3'd0, 150);
      app_switch = 1'b1;
      room_intensity = 8'd200;
      wait_state("cap_man_on", 3'd2, 100);
      check("cap_man_dim", int'(dim_level), 200);
      check("cap_man_src", int'(src_manual), 1);
      app_switch = 1'b0;
      wait_state("cap_man_idle", 3'd0, 150);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
